// File: rtl/legv8_pkg.sv
// Shared LEGv8 immediate-field definitions: format encodings, per-format
// field width and position, and the field mask used to splice an immediate
// into an instruction template.
package legv8_pkg;

  typedef enum logic [1:0] {
    FMT_D  = 2'd0,
    FMT_I  = 2'd1,
    FMT_CB = 2'd2,
    FMT_B  = 2'd3
  } fmt_e;

  localparam int D_W    = 9;
  localparam int D_LSB  = 12;
  localparam int I_W    = 12;
  localparam int I_LSB  = 10;
  localparam int CB_W   = 19;
  localparam int CB_LSB = 5;
  localparam int B_W    = 26;
  localparam int B_LSB  = 0;

  // Widest field; the field bus between stages is this wide.
  localparam int FIELD_W = B_W;

  function automatic logic [4:0] field_width(input fmt_e fmt);
    case (fmt)
      FMT_D:   return 5'(D_W);
      FMT_I:   return 5'(I_W);
      FMT_CB:  return 5'(CB_W);
      default: return 5'(B_W);
    endcase
  endfunction

  function automatic logic [4:0] field_lsb(input fmt_e fmt);
    case (fmt)
      FMT_D:   return 5'(D_LSB);
      FMT_I:   return 5'(I_LSB);
      FMT_CB:  return 5'(CB_LSB);
      default: return 5'(B_LSB);
    endcase
  endfunction

  // Ones over the immediate field of the given format, in instruction position.
  function automatic logic [31:0] field_mask(input fmt_e fmt);
    logic [31:0] ones;
    ones = (32'd1 << field_width(fmt)) - 32'd1;
    return ones << field_lsb(fmt);
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range check and narrowing of a 64-bit immediate to the
// immediate field of a LEGv8 format. Signed formats require all bits above
// the field's sign bit to match it; the I format requires the upper 52 bits
// to be zero. With IMM_ENC_SATURATE_EN defined, an out-of-range value is
// clamped to the nearest representable field value instead of truncated.
module imm_range_check
  import legv8_pkg::*;
(
  input  logic [63:0]        value,
  input  logic [1:0]         fmt,
  output logic               range_ok,
  output logic [FIELD_W-1:0] field
);

  // Per-format fit test, low-bit extraction and optional clamp
  always_comb begin
    range_ok = 1'b1;
    field    = '0;
    case (fmt_e'(fmt))
      FMT_D: begin
        range_ok = (&value[63:8]) | ~(|value[63:8]);
        field    = {17'd0, value[8:0]};
`ifdef IMM_ENC_SATURATE_EN
        if (!range_ok) field = value[63] ? 26'h000_0100 : 26'h000_00FF;
`endif
      end
      FMT_I: begin
        range_ok = ~(|value[63:12]);
        field    = {14'd0, value[11:0]};
`ifdef IMM_ENC_SATURATE_EN
        if (!range_ok) field = value[63] ? 26'h000_0000 : 26'h000_0FFF;
`endif
      end
      FMT_CB: begin
        range_ok = (&value[63:18]) | ~(|value[63:18]);
        field    = {7'd0, value[18:0]};
`ifdef IMM_ENC_SATURATE_EN
        if (!range_ok) field = value[63] ? 26'h004_0000 : 26'h003_FFFF;
`endif
      end
      default: begin
        range_ok = (&value[63:25]) | ~(|value[63:25]);
        field    = value[25:0];
`ifdef IMM_ENC_SATURATE_EN
        if (!range_ok) field = value[63] ? 26'h200_0000 : 26'h1FF_FFFF;
`endif
      end
    endcase
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready encoder that range-checks a 64-bit immediate,
// narrows it to the immediate field of a LEGv8 format and splices it into
// an instruction template. Counts range errors as they leave the block.
// Optional build macro: IMM_ENC_SATURATE_EN (clamp instead of truncate).
module imm_field_encoder
  import legv8_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_fmt,
  input  logic [31:0]          in_template,
  input  logic [63:0]          in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic               range_ok_p0;
  logic [FIELD_W-1:0] field_p0;

  logic               vld_p1;
  logic [1:0]         fmt_p1;
  logic [31:0]        template_p1;
  logic               range_ok_p1;
  logic [FIELD_W-1:0] field_p1;

  logic [31:0]        mask_p1;
  logic [31:0]        instr_p1;

  logic               vld_p2;
  logic [31:0]        instr_p2;
  logic               err_p2;
  logic [ERR_CNT_W-1:0] err_cnt;

  logic adv_p2;
  logic adv_p1;

  // No skid buffer: a full S1 frees up only when S2 can take its beat.
  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = adv_p2 | ~vld_p1;
  assign in_ready = adv_p1;

  // ---- stage 0 -> 1: range check on the incoming value
  imm_range_check u_range_check (
    .value    (in_value),
    .fmt      (in_fmt),
    .range_ok (range_ok_p0),
    .field    (field_p0)
  );

  // S1 occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
    end
  end

  // S1 payload, loaded on input acceptance
  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      fmt_p1      <= in_fmt;
      template_p1 <= in_template;
      range_ok_p1 <= range_ok_p0;
      field_p1    <= field_p0;
    end
  end

  // ---- stage 1 -> 2: splice the field into the template
  assign mask_p1  = field_mask(fmt_e'(fmt_p1));
  assign instr_p1 = (template_p1 & ~mask_p1) |
                    (({6'd0, field_p1} << field_lsb(fmt_e'(fmt_p1))) & mask_p1);

  // S2 occupancy and output payload; payload holds while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= instr_p1;
        err_p2   <= ~range_ok_p1;
      end
    end
  end

  // Saturating count of erroneous beats leaving the block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (vld_p2 && out_ready && err_p2 && !(&err_cnt)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign out_valid     = vld_p2;
  assign out_instr     = instr_p2;
  assign out_range_err = err_p2;
  assign err_count     = err_cnt;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder: reset state, per-format encoding and
// boundaries, backpressure ordering, reset with a full pipe, and counter
// saturation on a narrow-counter instance.
module tb_imm_field_encoder;

`ifdef IMM_ENC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [31:0] in_template;
  logic [63:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_range_err;
  logic [15:0] err_count;

  logic        in2_valid;
  logic        in2_ready;
  logic [1:0]  in2_fmt;
  logic [31:0] in2_template;
  logic [63:0] in2_value;
  logic        out2_valid;
  logic        out2_ready;
  logic [31:0] out2_instr;
  logic        out2_range_err;
  logic [1:0]  err2_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  imm_field_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_template(in_template), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_range_err(out_range_err), .err_count(err_count)
  );

  imm_field_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_fmt(in2_fmt),
    .in_template(in2_template), .in_value(in2_value),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_instr(out2_instr),
    .out_range_err(out2_range_err), .err_count(err2_count)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_range_err !== 1'b0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b instr=%h err=%b cnt=%0d, want 0/0/0/0",
               out_valid, out_instr, out_range_err, err_count);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_formats();
    logic [1:0]  fmt  [16];
    logic [31:0] tmpl [16];
    logic [63:0] val  [16];
    logic [31:0] etr  [16];
    logic [31:0] esat [16];
    logic        eerr [16];
    logic [31:0] want;
    fmt[0]=2'd0;  tmpl[0]=32'hF840_0000;  val[0]=64'hFFFF_FFFF_FFFF_FFF4; etr[0]=32'hF85F_4000;  esat[0]=32'hF85F_4000;  eerr[0]=0;
    fmt[1]=2'd2;  tmpl[1]=32'hB400_0000;  val[1]=64'h3_FFFF;              etr[1]=32'hB47F_FFE0;  esat[1]=32'hB47F_FFE0;  eerr[1]=0;
    fmt[2]=2'd2;  tmpl[2]=32'hB400_0000;  val[2]=64'h4_0000;              etr[2]=32'hB480_0000;  esat[2]=32'hB47F_FFE0;  eerr[2]=1;
    fmt[3]=2'd3;  tmpl[3]=32'h1400_0000;  val[3]=64'hFFFF_FFFF_FFFF_FFFF; etr[3]=32'h17FF_FFFF;  esat[3]=32'h17FF_FFFF;  eerr[3]=0;
    fmt[4]=2'd1;  tmpl[4]=32'h9100_0000;  val[4]=64'd4095;                etr[4]=32'h913F_FC00;  esat[4]=32'h913F_FC00;  eerr[4]=0;
    fmt[5]=2'd1;  tmpl[5]=32'h9100_0000;  val[5]=64'd4096;                etr[5]=32'h9100_0000;  esat[5]=32'h913F_FC00;  eerr[5]=1;
    fmt[6]=2'd0;  tmpl[6]=32'h0;          val[6]=64'd255;                 etr[6]=32'h000F_F000;  esat[6]=32'h000F_F000;  eerr[6]=0;
    fmt[7]=2'd0;  tmpl[7]=32'h0;          val[7]=64'hFFFF_FFFF_FFFF_FF00; etr[7]=32'h0010_0000;  esat[7]=32'h0010_0000;  eerr[7]=0;
    fmt[8]=2'd0;  tmpl[8]=32'h0;          val[8]=64'd256;                 etr[8]=32'h0010_0000;  esat[8]=32'h000F_F000;  eerr[8]=1;
    fmt[9]=2'd0;  tmpl[9]=32'h0;          val[9]=64'hFFFF_FFFF_FFFF_FEFF; etr[9]=32'h000F_F000;  esat[9]=32'h0010_0000;  eerr[9]=1;
    fmt[10]=2'd1; tmpl[10]=32'h9100_0000; val[10]=64'hFFFF_FFFF_FFFF_FFFF; etr[10]=32'h913F_FC00; esat[10]=32'h9100_0000; eerr[10]=1;
    fmt[11]=2'd0; tmpl[11]=32'hFFFF_FFFF; val[11]=64'h0;                  etr[11]=32'hFFE0_0FFF; esat[11]=32'hFFE0_0FFF; eerr[11]=0;
    fmt[12]=2'd3; tmpl[12]=32'h0;         val[12]=64'hFFFF_FFFF_FE00_0000; etr[12]=32'h0200_0000; esat[12]=32'h0200_0000; eerr[12]=0;
    fmt[13]=2'd3; tmpl[13]=32'h0;         val[13]=64'h200_0000;           etr[13]=32'h0200_0000; esat[13]=32'h01FF_FFFF; eerr[13]=1;
    fmt[14]=2'd2; tmpl[14]=32'h0;         val[14]=64'hFFFF_FFFF_FFFC_0000; etr[14]=32'h0080_0000; esat[14]=32'h0080_0000; eerr[14]=0;
    fmt[15]=2'd2; tmpl[15]=32'hFFFF_FFFF; val[15]=64'h0;                  etr[15]=32'hFF00_001F; esat[15]=32'hFF00_001F; eerr[15]=0;
    exp_cnt = 16'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want = SAT ? esat[i] : etr[i];
      @(posedge clk); #1;
      in_valid = 1'b1; in_fmt = fmt[i]; in_template = tmpl[i]; in_value = val[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fmt%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fmt%0d_early_valid: got %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== want || out_range_err !== eerr[i]) begin
        errors++;
        $display("FAIL fmt%0d_out: valid=%b instr=%h err=%b, want 1/%h/%b",
                 i, out_valid, out_instr, out_range_err, want, eerr[i]);
      end
      if (eerr[i]) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk); #1;
      checks++;
      if (err_count !== exp_cnt || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fmt%0d_count: cnt=%0d valid=%b, want %0d/0", i, err_count, out_valid, exp_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int ina = 0;
    int outn = 0;
    int occ = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] want;
    logic exp_rdy;
    for (int cyc = 0; cyc < 300 && outn < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid    = (ina < 8) && (cyc < 4 || $urandom_range(0, 1) == 1);
      in_fmt      = 2'd0;
      in_template = 32'hF840_0000;
      in_value    = 64'(ina);
      out_ready   = (cyc >= 4) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== held) begin
          errors++;
          $display("FAIL bp_hold: valid=%b instr=%h, want 1/%h", out_valid, out_instr, held);
        end
      end
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready: got %b want %b (occ=%0d)", in_ready, exp_rdy, occ);
      end
      if (out_valid && out_ready) begin
        want = 32'hF840_0000 | (32'(outn) << 12);
        checks++;
        if (out_instr !== want || out_range_err !== 1'b0) begin
          errors++;
          $display("FAIL bp_beat%0d: instr=%h err=%b, want %h/0", outn, out_instr, out_range_err, want);
        end
        outn++;
        occ--;
      end
      stalled = out_valid && !out_ready;
      held    = out_instr;
      if (in_valid && in_ready) begin
        ina++;
        occ++;
      end
    end
    checks++;
    if (outn != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d beats want 8", outn);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra_beat: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_fmt = 2'd0; in_template = 32'h0; in_value = 64'd256;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_full_setup: valid=%b ready=%b, want 1/0", out_valid, in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_range_err !== 1'b0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_full_async: valid=%b instr=%h err=%b cnt=%0d, want 0/0/0/0",
               out_valid, out_instr, out_range_err, err_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_full_stale%0d: valid=%b ready=%b, want 0/1", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_err_saturate();
    logic [1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    out2_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in2_valid = 1'b1; in2_fmt = 2'd0; in2_template = 32'h0; in2_value = 64'd256;
      @(posedge clk); #1;
      in2_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (err2_count !== want[k]) begin
        errors++;
        $display("FAIL sat_count%0d: got %0d want %0d", k, err2_count, want[k]);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_fmt = 2'd0; in_template = '0; in_value = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_fmt = 2'd0; in2_template = '0; in2_value = '0; out2_ready = 1'b0;
    exp_cnt = '0;
    test_reset();
    test_formats();
    test_backpressure();
    test_reset_full();
    test_err_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/imm_field_encoder.md
Name: imm_field_encoder

Overview:
- Narrowing counterpart of the 64-bit sign extender: takes a 64-bit signed or unsigned immediate plus a LEGv8 instruction template.
- Checks that the value fits the format's immediate field, truncates it and inserts it into the 32-bit instruction word.
- Sits between the program loader / branch-offset generator and instruction memory writes.
- Two-stage valid/ready pipeline with a range-error counter.

Parameters:
- ERR_CNT_W, 16, width of the saturating range-error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_fmt  in  2  format: 0=D (9b signed, bits [20:12]), 1=I (12b unsigned, [21:10]), 2=CB (19b signed, [23:5]), 3=B (26b signed, [25:0]).
- in_template  in  32  instruction with opcode/register fields.
- in_value  in  64  immediate, already scaled (word offsets for CB/B).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_instr  out  32  encoded instruction.
- out_range_err  out  1  value did not fit its field; qualified by out_valid.
- err_count  out  ERR_CNT_W  saturating count of range errors.

Behaviour:
- Reset: asynchronous while reset_n=0, mid-operation included. All pipeline valids clear, out_valid=0, out_instr=0, out_range_err=0, err_count=0, and any beats in flight are discarded. in_ready=1 from the first clock edge after release.
- Transfer rules: a beat transfers on in_valid&in_ready or on out_valid&out_ready. Output data must hold stable while out_valid=1 and out_ready=0.
- Stage 1 (S1) registers the following on acceptance:
  - fmt and template.
  - range_ok:
    - signed N-bit field: in_value[63:N-1] all equal.
    - I format: in_value[63:12]==0.
  - field = in_value[N-1:0].
- Stage 2 (S2) registers:
  - out_instr = (template with field bits cleared) | (field << lsb).
  - out_range_err = ~range_ok.
- Latency: exactly 2 cycles from input acceptance to out_valid when unstalled. Throughput is 1 beat per cycle.
- Stalls:
  - S2 advances when !S2.valid | out_ready.
  - S1 advances when S2 advances or S1 is empty.
  - in_ready = !S1.valid | S2 can advance. It is combinational from out_ready; there is no skid buffer.
  - Beats stay in order, with no loss or duplication under any valid/ready pattern.
- err_count increments by 1 when a beat with out_range_err=1 transfers out. It saturates at all-ones with no wrap.
- Template bits outside the field pass through unchanged. Template bits inside the field are always overwritten.
- Out-of-range value without SATURATE_EN: low N bits are inserted (truncation) and out_range_err=1.
- Boundaries:
  - D accepts -256..255.
  - I accepts 0..4095.
  - CB accepts -262144..262143.
  - B accepts -2^25..2^25-1.
  - A negative value in I format is an error.

Optional Feature:
- Macro IMM_ENC_SATURATE_EN.
- Defined: an out-of-range value is clamped before insertion.
  - Signed formats: to field max 2^(N-1)-1 if positive, field min -2^(N-1) if negative.
  - I format: to 4095 if in_value[63]=0, to 0 if negative.
  - out_range_err and err_count behave as without the macro.
- Undefined: truncation as described above; no clamp logic is synthesized.

Decomposition:
- Shared package (legv8_pkg) holds:
  - format encodings FMT_D/FMT_I/FMT_CB/FMT_B.
  - per-format field width and lsb constants.
  - a function returning the field mask.
- One sub-module: imm_range_check. It is combinational: value, fmt -> range_ok, field (including the clamp under the macro), and is instantiated in S1.

Test Plan:
- D, template 0xF8400000, value -12 (0xFFFFFFFFFFFFFFF4) -> out_instr 0xF85F4000, err=0, 2 cycles after acceptance.
- CB, template 0xB4000000, value 0x3FFFF -> 0xB47FFFE0, err=0. Value 0x40000:
  - without macro: 0xB4800000, err=1, err_count=1.
  - with IMM_ENC_SATURATE_EN: 0xB47FFFE0, err=1.
- B, template 0x14000000, value -1 -> 0x17FFFFFF, err=0. I, template 0x91000000, value 4095 -> 0x913FFC00, err=0. Value 4096 -> err=1.
- Backpressure: stream 8 beats with random in_valid and out_ready toggling -> identical ordered outputs, out_instr stable while stalled, in_ready=0 when both stages are full and out_ready=0.
- Reset asserted with both stages full -> out_valid drops immediately, err_count=0, no stale beat appears after release.
- err_count with ERR_CNT_W=2: five error beats -> count 1,2,3,3,3.
